tx_mapper: RTL and testbench
============================

Name: tx_mapper

Overview:
- Transmit-side counterpart of the JESD204 receive mapper. Feeds the AD9173 DAC path: L=8, M=4, F=4, 16-bit samples, 4 samples per converter pair per core clock.
- Accepts 256-bit application sample words on a valid/ready stream and buffers them in a small FIFO.
- Re-interleaves each word into eight 32-bit lanes in the JESD TX core (pg066) lane layout.
- Supplies tx_tdata every cycle once the core asserts tx_tready. Inserts zero (mid-scale) data and counts underflows when the source cannot keep up.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- PRIME, 2, entries required in the FIFO before streaming starts (1..DEPTH).
- CNT_W, 16, width of the saturating underflow counter.

Ports:
- clk  in  1  core clock (JESD core clock domain)
- rst  in  1  synchronous active-high reset
- enable  in  1  level; 0 forces IDLE and flushes the FIFO
- s_tdata  in  256  app word, MSB first: {s3_0_r..s0_0_r, s3_0_i..s0_0_i, s3_1_r..s0_1_r, s3_1_i..s0_1_i}, 16 bits each; s0_1_i at [15:0]
- s_tvalid  in  1  app data valid
- s_tready  out  1  FIFO can accept
- tx_tdata  out  256  lane n at [32n+31:32n]
- tx_tready  in  1  JESD TX core ready (high after ILA)
- clr_stats  in  1  one-cycle pulse, clears underflow_cnt
- underflow  out  1  one-cycle pulse per zero-filled beat in RUN
- underflow_cnt  out  CNT_W  saturating count of underflow beats
- state  out  2  0=IDLE, 1=FILL, 2=RUN
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset values: tx_tdata=0, s_tready=0, underflow=0, underflow_cnt=0, state=IDLE, fifo_level=0, FIFO empty.

Mapping (pure function, applied at pop):
- For converter c∈{0,1} and sample k∈{0..3}: W = {s<k>_<c>_r, s<k>_<c>_i} (32 bits).
- lane(4c+0)[8k+7:8k]=W[31:24], lane(4c+1)=W[23:16], lane(4c+2)=W[15:8], lane(4c+3)=W[7:0].
- This is the exact inverse of the receive mapper; RX(TX(x)) == x.

FIFO:
- Push when s_tvalid & s_tready.
- s_tready = !full & enable & !rst, registered from the next-cycle level; no combinational path from tx_tready.
- Simultaneous push and pop: level unchanged.

State machine:
- IDLE: tx_tdata=0. FIFO flushed each cycle while enable=0 or tx_tready=0. Go to FILL when enable & tx_tready.
- FILL: tx_tdata=0, no pop, no underflow reporting. Go to RUN when fifo_level ≥ PRIME. Go to IDLE if enable=0 or tx_tready=0.
- RUN, each cycle:
  - if FIFO is not empty: pop, and tx_tdata <= map(head) on the next edge.
  - else: tx_tdata <= 0, underflow pulses, counter increments (saturates at 2^CNT_W-1); stay in RUN.
  - Go to IDLE (with flush) when enable=0 or tx_tready=0; tx_tdata <= 0 on the same edge.

Latency:
- Word pushed into an empty FIFO in RUN appears on tx_tdata 2 cycles after the push edge (one FIFO write, one output register).
- In steady state, one word per clock.

Boundary conditions:
- clr_stats and an increment in the same cycle: clear wins; count reads 0.
- rst mid-RUN: all state returns to reset values on that edge; buffered data is discarded.
- tx_tready deasserting during RUN (link resync): buffered words are discarded, not replayed.

Decomposition:
- Package tx_mapper_pkg holds:
  - constants LANES=8, LANE_W=32, SAMP_W=16, SPC=4 (samples per clock);
  - the state enum (IDLE/FILL/RUN);
  - a function map_app_to_lanes(256b) -> 256b, shared with a future RX-side check.
- Sub-module tx_mapper_fifo: synchronous FIFO, DEPTH×256, with push/pop/flush/level/full/empty and show-ahead head output.

Test Plan:
- Mapping: enable=1, tx_tready=1, one word with s0_0_r=0x1234, s0_0_i=0x5678, all others 0, followed by continuous valid words -> first non-zero tx_tdata has [7:0]=0x12, [39:32]=0x34, [71:64]=0x56, [103:96]=0x78, all other bits 0. Also: random words through a model RX mapper -> output == input.
- Prime/latency: PRIME=2; push one word -> stays FILL, tx_tdata=0; push second -> RUN next cycle; first mapped word appears, then the second on the following cycle, in order.
- Underflow: in RUN, stop s_tvalid for 3 cycles after the FIFO drains -> 3 underflow pulses, tx_tdata=0 on those beats, underflow_cnt=3. Then clr_stats coincident with a 4th underflow -> underflow_cnt=0.
- Backpressure/full: DEPTH=4, tx_tready=0, enable=1 -> IDLE, flush active, s_tready=1 but level stays 0. Then raise tx_tready while s_tvalid is held high with tx not popping (FILL) -> level reaches 4, s_tready=0, no word lost or duplicated after RUN.
- Link drop: tx_tready 1→0 mid-RUN with 3 words buffered -> next edge state=IDLE, tx_tdata=0, fifo_level=0; on restore, FILL then RUN with fresh data only.
- Reset mid-operation: assert rst for 1 cycle during RUN with counter=5 -> all outputs at reset values on the next edge, underflow_cnt=0.

Source files
------------

// File: rtl/tx_mapper_pkg.sv
// Shared definitions for the JESD204 transmit mapper feeding the AD9173 path:
// lane geometry, the mapper state encoding and the app-word to lane shuffle.
package tx_mapper_pkg;

   localparam int LANES  = 8;
   localparam int LANE_W = 32;
   localparam int SAMP_W = 16;
   localparam int SPC    = 4;
   localparam int WORD_W = LANES * LANE_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   // Re-interleave one application word into the TX core lane layout.
   // For converter c and sample k the 32-bit word {real, imag} is split into
   // bytes; byte j (MSB first) lands in lane 4c+j at byte position k.
   // Converter 0 real/imag sit in the upper half of the app word, converter 1
   // real/imag in the lower half, sample 0 at the low end of each group.
   function automatic logic [WORD_W-1:0] map_app_to_lanes(input logic [WORD_W-1:0] app);
      logic [WORD_W-1:0] lanes;
      logic [31:0]       w;
      int                rBase;
      int                iBase;
      lanes = '0;
      for (int c = 0; c < 2; c++) begin
         rBase = (c == 0) ? 192 : 64;
         iBase = (c == 0) ? 128 : 0;
         for (int k = 0; k < SPC; k++) begin
            w = {app[rBase + SAMP_W*k +: SAMP_W], app[iBase + SAMP_W*k +: SAMP_W]};
            for (int j = 0; j < 4; j++) begin
               lanes[LANE_W*(4*c + j) + 8*k +: 8] = w[31 - 8*j -: 8];
            end
         end
      end
      return lanes;
   endfunction

endpackage

// File: rtl/tx_mapper_fifo.sv
// Small synchronous show-ahead FIFO buffering application words ahead of the
// lane mapper. Flush empties it in one cycle and overrides push and pop.
module tx_mapper_fifo
   import tx_mapper_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = WORD_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [$clog2(DEPTH):0]     levelNext_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             doPush;
   logic             doPop;

   assign full_o      = (level_q == LVL_W'(DEPTH));
   assign empty_o     = (level_q == '0);
   assign head_o      = mem[rdPtr_q];
   assign level_o     = level_q;
   assign levelNext_o = level_d;

   // Work out the effective push/pop and the next pointer and occupancy values;
   // a flush discards everything, and push+pop together leave the level alone.
   always_comb begin
      doPush  = push_i & ~full_o & ~flush_i;
      doPop   = pop_i & ~empty_o & ~flush_i;
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         level_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
         if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
         case ({doPush, doPop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Pointer and occupancy registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr_q] <= wdata_i;
   end

endmodule

// File: rtl/tx_mapper.sv
// Transmit-side JESD204 mapper: buffers app sample words, primes the FIFO,
// then streams one lane-mapped word per core clock to the TX core, filling
// with mid-scale zeros and counting underflows when the source falls behind.
module tx_mapper
   import tx_mapper_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PRIME = 2,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [WORD_W-1:0]        s_tdata,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   output logic [WORD_W-1:0]        tx_tdata,
   input  logic                     tx_tready,
   input  logic                     clr_stats,
   output logic                     underflow,
   output logic [CNT_W-1:0]         underflow_cnt,
   output logic [1:0]               state,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   state_e             state_q, state_d;
   logic [WORD_W-1:0]  txData_q, txData_d;
   logic               underflow_q, underflow_d;
   logic [CNT_W-1:0]   underflowCnt_q, underflowCnt_d;
   logic               sReady_q, sReady_d;

   logic               fifoPush;
   logic               fifoPop;
   logic               fifoFlush;
   logic [WORD_W-1:0]  fifoHead;
   logic [LVL_W-1:0]   fifoLevel;
   logic [LVL_W-1:0]   fifoLevelNext;
   logic               fifoFull;
   logic               fifoEmpty;
   logic               linkUp;

   assign linkUp   = enable & tx_tready;
   assign fifoPush = s_tvalid & sReady_q & ~fifoFull;

   tx_mapper_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifoPush),
      .pop_i       (fifoPop),
      .flush_i     (fifoFlush),
      .wdata_i     (s_tdata),
      .head_o      (fifoHead),
      .level_o     (fifoLevel),
      .levelNext_o (fifoLevelNext),
      .full_o      (fifoFull),
      .empty_o     (fifoEmpty)
   );

   // Mapper sequencing: hold zeros until the link is up and the FIFO is primed,
   // then pop one word per cycle; a lost link drops straight back to IDLE and
   // discards whatever is buffered so nothing stale is replayed after resync.
   always_comb begin
      state_d     = state_q;
      txData_d    = txData_q;
      underflow_d = 1'b0;
      fifoPop     = 1'b0;
      fifoFlush   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            txData_d = '0;
            if (!linkUp) fifoFlush = 1'b1;
            else         state_d   = ST_FILL;
         end
         ST_FILL: begin
            txData_d = '0;
            if (!linkUp) begin
               fifoFlush = 1'b1;
               state_d   = ST_IDLE;
            end else if (fifoLevel >= LVL_W'(PRIME)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!linkUp) begin
               fifoFlush = 1'b1;
               txData_d  = '0;
               state_d   = ST_IDLE;
            end else if (!fifoEmpty) begin
               fifoPop  = 1'b1;
               txData_d = map_app_to_lanes(fifoHead);
            end else begin
               txData_d    = '0;
               underflow_d = 1'b1;
            end
         end
         default: begin
            txData_d = '0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // Underflow statistics and source-side ready; a clear request beats a
   // coincident increment, and ready comes from the post-edge FIFO level so
   // the app side never sees a combinational path from the TX core.
   always_comb begin
      underflowCnt_d = underflowCnt_q;
      if (clr_stats)
         underflowCnt_d = '0;
      else if (underflow_d && (underflowCnt_q != {CNT_W{1'b1}}))
         underflowCnt_d = underflowCnt_q + CNT_W'(1);
      sReady_d = (fifoLevelNext < LVL_W'(DEPTH)) & enable;
   end

   // Output and control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         txData_q       <= '0;
         underflow_q    <= 1'b0;
         underflowCnt_q <= '0;
         sReady_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         txData_q       <= txData_d;
         underflow_q    <= underflow_d;
         underflowCnt_q <= underflowCnt_d;
         sReady_q       <= sReady_d;
      end
   end

   assign s_tready      = sReady_q;
   assign tx_tdata      = txData_q;
   assign underflow     = underflow_q;
   assign underflow_cnt = underflowCnt_q;
   assign state         = state_q;
   assign fifo_level    = fifoLevel;

endmodule

// File: tb/tb_tx_mapper.sv
// Directed testbench for tx_mapper. A second instance with PRIME equal to
// DEPTH is used to hold the FIFO in FILL long enough to observe it full.
module tb_tx_mapper;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic [255:0] sTdata;
   logic         sTvalid;
   logic         txTready;
   logic         clrStats;

   logic         sTready;
   logic [255:0] txTdata;
   logic         underflowPulse;
   logic [15:0]  underflowCnt;
   logic [1:0]   stateOut;
   logic [2:0]   fifoLevel;

   logic         auxReady;
   logic [255:0] auxTx;
   logic         auxUnder;
   logic [15:0]  auxCnt;
   logic [1:0]   auxState;
   logic [2:0]   auxLevel;

   int           vecCount  = 0;
   int           missCount = 0;
   int           idx;
   int           m;
   logic         rdy;
   logic [255:0] words [16];
   logic [255:0] wordP, wordQ, wordR, wordS, expMap;

   tx_mapper #(.DEPTH(4), .PRIME(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .s_tdata(sTdata), .s_tvalid(sTvalid),
      .s_tready(sTready), .tx_tdata(txTdata), .tx_tready(txTready), .clr_stats(clrStats),
      .underflow(underflowPulse), .underflow_cnt(underflowCnt), .state(stateOut),
      .fifo_level(fifoLevel)
   );

   tx_mapper #(.DEPTH(4), .PRIME(4), .CNT_W(16)) dutFull (
      .clk(clk), .rst(rst), .enable(enable), .s_tdata(sTdata), .s_tvalid(sTvalid),
      .s_tready(auxReady), .tx_tdata(auxTx), .tx_tready(txTready), .clr_stats(clrStats),
      .underflow(auxUnder), .underflow_cnt(auxCnt), .state(auxState),
      .fifo_level(auxLevel)
   );

   // Free-running core clock.
   always #5 clk = ~clk;

   // Receive-side mapper model: gathers lane bytes back into the app word.
   function automatic logic [255:0] rxMap(input logic [255:0] lanes);
      logic [255:0] app;
      logic [31:0]  w;
      int           rBase;
      int           iBase;
      app = '0;
      for (int c = 0; c < 2; c++) begin
         rBase = (c == 0) ? 192 : 64;
         iBase = (c == 0) ? 128 : 0;
         for (int k = 0; k < 4; k++) begin
            w = {lanes[32*(4*c)   + 8*k +: 8], lanes[32*(4*c+1) + 8*k +: 8],
                 lanes[32*(4*c+2) + 8*k +: 8], lanes[32*(4*c+3) + 8*k +: 8]};
            app[rBase + 16*k +: 16] = w[31:16];
            app[iBase + 16*k +: 16] = w[15:0];
         end
      end
      return app;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // One beat on the aux instance, advancing the source word on acceptance.
   task automatic beatAux();
      rdy = auxReady;
      applyStimulus();
      if (sTvalid && rdy) idx++;
      sTdata = words[idx];
   endtask

   // One beat on the main instance, advancing the source word on acceptance.
   task automatic beatMain();
      rdy = sTready;
      applyStimulus();
      if (sTvalid && rdy) idx++;
      sTdata = words[idx];
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_tdata"}, txTdata, '0);
      checkOutput({tag, "_sready"}, {255'd0, sTready}, '0);
      checkOutput({tag, "_uflow"}, {255'd0, underflowPulse}, '0);
      checkOutput({tag, "_cnt"}, {240'd0, underflowCnt}, '0);
      checkOutput({tag, "_state"}, {254'd0, stateOut}, 256'd0);
      checkOutput({tag, "_level"}, {253'd0, fifoLevel}, '0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         words[i] = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom | 32'h1};
      wordP = '0;
      wordP[207:192] = 16'h1234;
      wordP[143:128] = 16'h5678;
      expMap = '0;
      expMap[7:0]   = 8'h12;
      expMap[39:32] = 8'h34;
      expMap[71:64] = 8'h56;
      expMap[103:96] = 8'h78;
      wordQ = words[13] ^ words[14];
      wordR = words[15];
      wordS = words[2];

      rst = 1'b1; enable = 1'b0; txTready = 1'b0; sTvalid = 1'b0;
      sTdata = '0; clrStats = 1'b0;
      applyStimulus();
      applyStimulus();
      checkResetState("reset");

      // Link not ready: FIFO is flushed every cycle even though ready is high.
      rst = 1'b0; enable = 1'b1; sTvalid = 1'b1; sTdata = words[0];
      applyStimulus();
      applyStimulus();
      checkOutput("idle_state", {254'd0, stateOut}, 256'd0);
      checkOutput("idle_sready", {255'd0, sTready}, 256'd1);
      checkOutput("idle_level", {253'd0, fifoLevel}, 256'd0);
      checkOutput("idle_tdata", txTdata, '0);

      // Fill the PRIME=DEPTH instance to full, then check in-order drain.
      txTready = 1'b1; idx = 0; sTdata = words[0];
      repeat (4) beatAux();
      checkOutput("full_level", {253'd0, auxLevel}, 256'd4);
      checkOutput("full_sready", {255'd0, auxReady}, 256'd0);
      checkOutput("full_state", {254'd0, auxState}, 256'd1);
      checkOutput("full_accepted", idx, 256'd4);
      checkOutput("full_tdata", auxTx, '0);
      m = 0;
      repeat (8) begin
         beatAux();
         if (auxTx != '0) begin
            checkOutput("full_order", rxMap(auxTx), words[m]);
            m++;
         end
      end
      checkOutput("full_count", m, 256'd7);

      // Mapping, priming and latency on the PRIME=2 instance.
      rst = 1'b1; enable = 1'b0; txTready = 1'b0; sTvalid = 1'b0;
      applyStimulus();
      rst = 1'b0; enable = 1'b1; txTready = 1'b1;
      applyStimulus();
      sTvalid = 1'b1; sTdata = wordP;
      applyStimulus();
      checkOutput("prime1_state", {254'd0, stateOut}, 256'd1);
      checkOutput("prime1_level", {253'd0, fifoLevel}, 256'd1);
      checkOutput("prime1_tdata", txTdata, '0);
      sTdata = wordQ;
      applyStimulus();
      checkOutput("prime2_state", {254'd0, stateOut}, 256'd1);
      checkOutput("prime2_level", {253'd0, fifoLevel}, 256'd2);
      sTvalid = 1'b0;
      applyStimulus();
      checkOutput("run_state", {254'd0, stateOut}, 256'd2);
      checkOutput("run_tdata0", txTdata, '0);
      applyStimulus();
      checkOutput("map_const", txTdata, expMap);
      checkOutput("map_level", {253'd0, fifoLevel}, 256'd1);
      applyStimulus();
      checkOutput("map_second", rxMap(txTdata), wordQ);
      checkOutput("map_drained", {253'd0, fifoLevel}, 256'd0);

      // Word pushed into an empty FIFO while running shows two cycles later.
      sTvalid = 1'b1; sTdata = wordR;
      applyStimulus();
      checkOutput("lat_uflow", {255'd0, underflowPulse}, 256'd1);
      checkOutput("lat_zero", txTdata, '0);
      sTvalid = 1'b0; clrStats = 1'b1;
      applyStimulus();
      checkOutput("lat_word", rxMap(txTdata), wordR);
      checkOutput("lat_noflow", {255'd0, underflowPulse}, 256'd0);
      checkOutput("clr_cnt", {240'd0, underflowCnt}, 256'd0);
      clrStats = 1'b0;

      // Three starved beats, then a clear that coincides with a fourth.
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("uf_pulse", {255'd0, underflowPulse}, 256'd1);
         checkOutput("uf_zero", txTdata, '0);
      end
      checkOutput("uf_cnt3", {240'd0, underflowCnt}, 256'd3);
      clrStats = 1'b1;
      applyStimulus();
      checkOutput("uf_clr_pulse", {255'd0, underflowPulse}, 256'd1);
      checkOutput("uf_clr_wins", {240'd0, underflowCnt}, 256'd0);
      clrStats = 1'b0;
      repeat (4) applyStimulus();
      sTvalid = 1'b1; sTdata = wordS;
      applyStimulus();
      sTvalid = 1'b0;
      checkOutput("uf_cnt5", {240'd0, underflowCnt}, 256'd5);
      checkOutput("uf_buffered", {253'd0, fifoLevel}, 256'd1);

      // Reset while running with a buffered word and a non-zero count.
      rst = 1'b1;
      applyStimulus();
      checkResetState("midrst");
      rst = 1'b0;

      // Link drop mid-RUN with three words buffered, then fresh restart.
      idx = 8; sTdata = words[8];
      applyStimulus();
      sTvalid = 1'b1;
      repeat (3) beatMain();
      beatMain();
      checkOutput("drop_pre_word", rxMap(txTdata), words[8]);
      checkOutput("drop_pre_level", {253'd0, fifoLevel}, 256'd3);
      txTready = 1'b0; sTvalid = 1'b0;
      applyStimulus();
      checkOutput("drop_state", {254'd0, stateOut}, 256'd0);
      checkOutput("drop_tdata", txTdata, '0);
      checkOutput("drop_level", {253'd0, fifoLevel}, 256'd0);
      checkOutput("drop_uflow", {255'd0, underflowPulse}, 256'd0);
      txTready = 1'b1; sTvalid = 1'b1; sTdata = words[idx];
      checkOutput("drop_idx", idx, 256'd12);
      beatMain();
      checkOutput("restore_fill", {254'd0, stateOut}, 256'd1);
      beatMain();
      beatMain();
      sTvalid = 1'b0;
      checkOutput("restore_run", {254'd0, stateOut}, 256'd2);
      applyStimulus();
      checkOutput("restore_word0", rxMap(txTdata), words[12]);
      applyStimulus();
      checkOutput("restore_word1", rxMap(txTdata), words[13]);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
